// File: rtl/psm_pkg.sv
// Shared types and sizing helpers for the multi-rail PSM controller.
// Imported by the rail channel and the top level.
package psm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REGULATE = 2'd1,
    CLAMP    = 2'd2,
    FAULT    = 2'd3
  } rail_state_t;

  // Phase offset of rail i: rails spread evenly over one PWM period.
  function automatic int phase_off(int res, int n, int i);
    return i * ((1 << res) / n);
  endfunction

  // Bits needed to hold 0..max_val.
  function automatic int cnt_w(int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/psm_rail_channel.sv
// One PSM rail: signed error, hysteretic band, clamp-hold,
// emergency boost and consecutive-emergency fault latch.
module psm_rail_channel
  import psm_pkg::*;
#(
  parameter int              ADC_W       = 12,
  parameter logic [ADC_W-1:0] V_REF      = 12'd3150,
  parameter logic [ADC_W-1:0] BASE_LOW   = 12'd3100,
  parameter logic [ADC_W-1:0] BASE_HIGH  = 12'd3250,
  parameter logic [ADC_W-1:0] V_MAX      = 12'd3245,
  parameter int              OV_MARGIN   = 180,
  parameter int              EMERGENCY   = 400,
  parameter int              CLAMP_HOLD  = 6,
  parameter int              EMERG_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic [ADC_W-1:0] volt_i,
  input  logic             drdy_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             gate_i,
  output logic             req_o,
  output logic [ADC_W:0]   err_o,
  output logic             emerg_o,
  output logic             clamp_o,
  output logic             fault_o
);

  localparam int HW = cnt_w(CLAMP_HOLD);
  localparam int EW = cnt_w(EMERG_LIMIT);
  localparam logic [HW-1:0] HOLD_LD = HW'(CLAMP_HOLD);
  localparam logic [EW-1:0] EM_MAX  = EW'(EMERG_LIMIT);

  rail_state_t     state_q, state_d;
  logic            reg_q, reg_d;
  logic            req_q, req_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [EW-1:0]   emc_q, emc_d;

  logic signed [ADC_W:0]   err;
  logic signed [ADC_W+1:0] err_x, volt_x, lo, hi;
  logic                    emerg, over, reg_nx;
  logic [EW-1:0]           emc_nx;

  // Error and band limits; band is widened by 2 bits so nothing truncates.
  always_comb begin
    err    = $signed({1'b0, V_REF}) - $signed({1'b0, volt_i});
    err_x  = {err[ADC_W], err};
    volt_x = {2'b00, volt_i};
    lo     = $signed({2'b00, BASE_LOW}) - (err_x >>> 1);
    hi     = $signed({2'b00, BASE_HIGH}) - (err_x >>> 2);
    emerg  = int'(err) > EMERGENCY;
    over   = (int'(err) < -OV_MARGIN) | (volt_i > V_MAX);
  end

  // Next state: enable drop, then fault entry, then clamp, then regulation.
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    req_d   = req_q;
    hold_d  = hold_q;
    emc_d   = emc_q;
    if (!emerg)              emc_nx = '0;
    else if (emc_q == EM_MAX) emc_nx = EM_MAX;
    else                     emc_nx = emc_q + 1'b1;
    reg_nx = reg_q;
    if (volt_x < lo)      reg_nx = 1'b1;
    else if (volt_x > hi) reg_nx = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (en_i) begin
          state_d = REGULATE;
          reg_d   = 1'b0;
        end
      end
      REGULATE, CLAMP: begin
        if (!en_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          reg_d   = 1'b0;
          hold_d  = '0;
          emc_d   = '0;
        end else if (drdy_i) begin
          emc_d = emc_nx;
          if (emc_nx == EM_MAX) begin
            state_d = FAULT;
            req_d   = 1'b0;
          end else if (over) begin
            state_d = CLAMP;
            hold_d  = HOLD_LD;
            reg_d   = 1'b0;
            req_d   = 1'b0;
          end else if (state_q == REGULATE) begin
            reg_d = reg_nx;
            req_d = (gate_i & reg_nx) | emerg;
          end else begin
            req_d = 1'b0;
            if (hold_q == HW'(1)) begin
              state_d = REGULATE;
              reg_d   = 1'b0;
              hold_d  = '0;
            end else begin
              hold_d = hold_q - 1'b1;
            end
          end
        end
      end
      FAULT: begin
        req_d = 1'b0;
        if (clr_i && !emerg) begin
          state_d = IDLE;
          reg_d   = 1'b0;
          hold_d  = '0;
          emc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rail state registers.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= IDLE;
      reg_q   <= 1'b0;
      req_q   <= 1'b0;
      hold_q  <= '0;
      emc_q   <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
      emc_q   <= emc_d;
    end
  end

  assign req_o   = req_q;
  assign err_o   = err;
  assign emerg_o = emerg;
  assign clamp_o = (state_q == CLAMP);
  assign fault_o = (state_q == FAULT);

endmodule

// File: rtl/psm_multi_rail.sv
// N-rail PSM controller: shared PWM base counter with per-rail
// phase offsets feeding one channel per rail.
module psm_multi_rail
  import psm_pkg::*;
#(
  parameter int N_RAILS    = 2,
  parameter int ADC_W      = 12,
  parameter int RESOLUTION = 9,
  parameter int DUTY       = 225,
  parameter logic [N_RAILS*ADC_W-1:0] V_REF     = {2{12'd3150}},
  parameter logic [N_RAILS*ADC_W-1:0] BASE_LOW  = {2{12'd3100}},
  parameter logic [N_RAILS*ADC_W-1:0] BASE_HIGH = {2{12'd3250}},
  parameter logic [N_RAILS*ADC_W-1:0] V_MAX     = {2{12'd3245}},
  parameter int OV_MARGIN   = 180,
  parameter int EMERGENCY   = 400,
  parameter int CLAMP_HOLD  = 6,
  parameter int EMERG_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset_in,
  input  logic [N_RAILS*ADC_W-1:0]   volt_in,
  input  logic [N_RAILS-1:0]         drdy_in,
  input  logic [N_RAILS-1:0]         rail_enable,
  input  logic [N_RAILS-1:0]         fault_clear,
  output logic [N_RAILS-1:0]         apsm_request,
  output logic [N_RAILS*(ADC_W+1)-1:0] error_out,
  output logic [N_RAILS-1:0]         emergency,
  output logic [N_RAILS-1:0]         clamp_active,
  output logic [N_RAILS-1:0]         fault
);

  logic [RESOLUTION-1:0] cnt_q, cnt_d;

  // Free-running PWM base; wraps naturally at 2**RESOLUTION.
  always_comb cnt_d = cnt_q + 1'b1;

  // Base counter register.
  always_ff @(posedge clk) begin
    if (reset_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < N_RAILS; i++) begin : g_rail
    localparam logic [RESOLUTION-1:0] OFF =
      RESOLUTION'(phase_off(RESOLUTION, N_RAILS, i));
    logic [RESOLUTION-1:0] ph;
    logic                  gate;
    assign ph   = cnt_q + OFF;
    assign gate = int'(ph) < DUTY;

    psm_rail_channel #(
      .ADC_W      (ADC_W),
      .V_REF      (V_REF[i*ADC_W +: ADC_W]),
      .BASE_LOW   (BASE_LOW[i*ADC_W +: ADC_W]),
      .BASE_HIGH  (BASE_HIGH[i*ADC_W +: ADC_W]),
      .V_MAX      (V_MAX[i*ADC_W +: ADC_W]),
      .OV_MARGIN  (OV_MARGIN),
      .EMERGENCY  (EMERGENCY),
      .CLAMP_HOLD (CLAMP_HOLD),
      .EMERG_LIMIT(EMERG_LIMIT)
    ) u_ch (
      .clk     (clk),
      .reset_in(reset_in),
      .volt_i  (volt_in[i*ADC_W +: ADC_W]),
      .drdy_i  (drdy_in[i]),
      .en_i    (rail_enable[i]),
      .clr_i   (fault_clear[i]),
      .gate_i  (gate),
      .req_o   (apsm_request[i]),
      .err_o   (error_out[i*(ADC_W+1) +: ADC_W+1]),
      .emerg_o (emergency[i]),
      .clamp_o (clamp_active[i]),
      .fault_o (fault[i])
    );
  end

endmodule

// File: tb/tb_psm_multi_rail.sv
// Directed bench for psm_multi_rail: reset, regulation/phasing,
// clamp-hold, fault latch, emergency override, enable drop.
module tb_psm_multi_rail;

  logic        clk;
  logic        reset_in;
  logic [23:0] volt_in;
  logic [1:0]  drdy_in;
  logic [1:0]  rail_enable;
  logic [1:0]  fault_clear;
  logic [1:0]  apsm_request;
  logic [25:0] error_out;
  logic [1:0]  emergency;
  logic [1:0]  clamp_active;
  logic [1:0]  fault;

  int vecs = 0;
  int errs = 0;
  int tcnt = 0;
  logic [1:0] exp_req = 2'b00;

  psm_multi_rail dut (
    .clk         (clk),
    .reset_in    (reset_in),
    .volt_in     (volt_in),
    .drdy_in     (drdy_in),
    .rail_enable (rail_enable),
    .fault_clear (fault_clear),
    .apsm_request(apsm_request),
    .error_out   (error_out),
    .emergency   (emergency),
    .clamp_active(clamp_active),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    tcnt = reset_in ? 0 : (tcnt + 1) % 512;
    #1;
  endtask

  function automatic logic gate_of(int r);
    return ((tcnt + r * 256) % 512) < 225;
  endfunction

  task automatic set_volt(int r, logic [11:0] v);
    volt_in[r*12 +: 12] = v;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    drdy_in = 2'b11;
    rail_enable = 2'b11;
    fault_clear = 2'b00;
    set_volt(0, 12'd2700);
    set_volt(1, 12'd2700);
    repeat (3) tick();
    vecs++;
    if ({apsm_request, clamp_active, fault} !== 6'b0) begin
      errs++;
      $display("FAIL reset_out: got %b want 000000",
               {apsm_request, clamp_active, fault});
    end
    vecs++;
    if (dut.cnt_q !== 9'd0) begin
      errs++;
      $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q);
    end
    reset_in = 1'b0;
    drdy_in = 2'b00;
    rail_enable = 2'b00;
    set_volt(0, 12'd3150);
    set_volt(1, 12'd3150);
    tick();
    vecs++;
    if (dut.cnt_q !== 9'd1) begin
      errs++;
      $display("FAIL release_cnt: got %0d want 1", dut.cnt_q);
    end
    vecs++;
    if ({apsm_request, clamp_active, fault} !== 6'b0) begin
      errs++;
      $display("FAIL release_out: got %b want 000000",
               {apsm_request, clamp_active, fault});
    end
  endtask

  task automatic test_regulate();
    set_volt(0, 12'd3000);
    set_volt(1, 12'd3000);
    rail_enable = 2'b11;
    tick();
    vecs++;
    if (error_out[12:0] !== 13'd150 || emergency !== 2'b00) begin
      errs++;
      $display("FAIL reg_err: got %0d/%b want 150/00",
               error_out[12:0], emergency);
    end
    for (int k = 0; k < 600; k++) begin
      drdy_in = (k % 3 == 0) ? 2'b11 : 2'b00;
      if (drdy_in[0]) exp_req = {gate_of(1), gate_of(0)};
      tick();
      vecs++;
      if (apsm_request !== exp_req) begin
        errs++;
        $display("FAIL reg_req k=%0d: got %b want %b",
                 k, apsm_request, exp_req);
      end
    end
    drdy_in = 2'b00;
    vecs++;
    if (dut.g_rail[0].u_ch.reg_q !== 1'b1) begin
      errs++;
      $display("FAIL reg_flag: got %b want 1", dut.g_rail[0].u_ch.reg_q);
    end
  endtask

  task automatic test_clamp();
    set_volt(0, 12'd3245);
    drdy_in = 2'b01;
    exp_req[0] = gate_of(0);
    tick();
    drdy_in = 2'b00;
    vecs++;
    if (clamp_active !== 2'b00 || apsm_request !== exp_req) begin
      errs++;
      $display("FAIL vmax_edge: got %b/%b want 00/%b",
               clamp_active, apsm_request, exp_req);
    end
    set_volt(0, 12'd3260);
    drdy_in = 2'b01;
    exp_req[0] = 1'b0;
    tick();
    drdy_in = 2'b00;
    vecs++;
    if (clamp_active !== 2'b01 || apsm_request !== exp_req) begin
      errs++;
      $display("FAIL clamp_in: got %b/%b want 01/%b",
               clamp_active, apsm_request, exp_req);
    end
    set_volt(0, 12'd3150);
    for (int d = 1; d <= 6; d++) begin
      drdy_in = 2'b01;
      tick();
      drdy_in = 2'b00;
      tick();
      vecs++;
      if (clamp_active[0] !== (d < 6) || apsm_request !== exp_req) begin
        errs++;
        $display("FAIL clamp_hold d=%0d: got %b/%b want %b/%b",
                 d, clamp_active[0], apsm_request, d < 6, exp_req);
      end
    end
    vecs++;
    if (dut.g_rail[0].u_ch.reg_q !== 1'b0) begin
      errs++;
      $display("FAIL clamp_flag: got %b want 0", dut.g_rail[0].u_ch.reg_q);
    end
    drdy_in = 2'b01;
    tick();
    drdy_in = 2'b00;
    vecs++;
    if (apsm_request !== exp_req) begin
      errs++;
      $display("FAIL clamp_exit: got %b want %b", apsm_request, exp_req);
    end
  endtask

  task automatic test_fault();
    set_volt(0, 12'd2750);
    #1;
    vecs++;
    if (emergency[0] !== 1'b0) begin
      errs++;
      $display("FAIL emerg_400: got %b want 0", emergency[0]);
    end
    set_volt(0, 12'd2749);
    #1;
    vecs++;
    if (emergency[0] !== 1'b1) begin
      errs++;
      $display("FAIL emerg_401: got %b want 1", emergency[0]);
    end
    set_volt(0, 12'd2700);
    #1;
    vecs++;
    if (error_out[12:0] !== 13'd450) begin
      errs++;
      $display("FAIL err_450: got %0d want 450", error_out[12:0]);
    end
    for (int n = 1; n <= 8; n++) begin
      drdy_in = 2'b01;
      exp_req[0] = (n < 8);
      tick();
      drdy_in = 2'b00;
      vecs++;
      if (apsm_request !== exp_req || fault !== {1'b0, n == 8}) begin
        errs++;
        $display("FAIL emerg_run n=%0d: got %b/%b want %b/%b",
                 n, apsm_request, fault, exp_req, {1'b0, n == 8});
      end
    end
    fault_clear = 2'b01;
    tick();
    fault_clear = 2'b00;
    rail_enable = 2'b10;
    tick();
    rail_enable = 2'b11;
    tick();
    vecs++;
    if (fault !== 2'b01) begin
      errs++;
      $display("FAIL fault_hold: got %b want 01", fault);
    end
    set_volt(0, 12'd3150);
    #1;
    fault_clear = 2'b01;
    tick();
    fault_clear = 2'b00;
    vecs++;
    if (fault !== 2'b00 || apsm_request !== exp_req) begin
      errs++;
      $display("FAIL fault_clr: got %b/%b want 00/%b",
               fault, apsm_request, exp_req);
    end
    tick();
  endtask

  task automatic test_emerg_gate();
    int w = 0;
    while (gate_of(0) && w < 600) begin
      tick();
      w++;
    end
    vecs++;
    if (w >= 600) begin
      errs++;
      $display("FAIL wait_gate_low: got timeout want gate=0");
    end
    set_volt(0, 12'd2700);
    drdy_in = 2'b01;
    exp_req[0] = 1'b1;
    tick();
    drdy_in = 2'b00;
    vecs++;
    if (apsm_request !== exp_req) begin
      errs++;
      $display("FAIL emerg_gate: got %b want %b", apsm_request, exp_req);
    end
    set_volt(0, 12'd3150);
    drdy_in = 2'b01;
    exp_req[0] = 1'b0;
    tick();
    drdy_in = 2'b00;
    vecs++;
    if (apsm_request !== exp_req) begin
      errs++;
      $display("FAIL emerg_off: got %b want %b", apsm_request, exp_req);
    end
  endtask

  task automatic test_enable_drop();
    int w = 0;
    set_volt(0, 12'd3000);
    while (!gate_of(0) && w < 600) begin
      tick();
      w++;
    end
    vecs++;
    if (w >= 600) begin
      errs++;
      $display("FAIL wait_gate_high: got timeout want gate=1");
    end
    drdy_in = 2'b01;
    exp_req[0] = 1'b1;
    tick();
    vecs++;
    if (apsm_request !== exp_req) begin
      errs++;
      $display("FAIL pre_drop: got %b want %b", apsm_request, exp_req);
    end
    rail_enable = 2'b10;
    drdy_in = 2'b11;
    exp_req = {gate_of(1), 1'b0};
    tick();
    drdy_in = 2'b00;
    vecs++;
    if (apsm_request !== exp_req || clamp_active !== 2'b00 ||
        fault !== 2'b00) begin
      errs++;
      $display("FAIL en_drop: got %b/%b/%b want %b/00/00",
               apsm_request, clamp_active, fault, exp_req);
    end
    drdy_in = 2'b01;
    tick();
    drdy_in = 2'b00;
    vecs++;
    if (apsm_request !== exp_req) begin
      errs++;
      $display("FAIL idle_stay: got %b want %b", apsm_request, exp_req);
    end
  endtask

  initial begin
    volt_in = '0;
    drdy_in = '0;
    rail_enable = '0;
    fault_clear = '0;
    reset_in = 1'b1;
    test_reset();
    test_regulate();
    test_clamp();
    test_fault();
    test_emerg_gate();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
